// File: rtl/pixel_write_sink_pkg.sv
// ---------------------------------------------------------------------------
// pixel_write_sink_pkg
// Shared definitions for the pixel-plot consumer: screen geometry, field
// widths, the buffered pixel record, the write-FSM state type and the
// (x, y) -> linear framebuffer address helper.
// ---------------------------------------------------------------------------
package pixel_write_sink_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam int COLOUR_W = 3;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int ADDR_W   = 15;

   localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

   typedef struct packed {
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;

   localparam int PIXEL_W = $bits(pixel_t);   // 18

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   // Linear address y*screen_w + x. For the native 160-wide screen this is
   // y*128 + y*32 + x, i.e. two shifted adds instead of a multiplier; the
   // screen_w test is a constant at every call site and folds away.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y,
                                                    input int             screen_w);
      logic [ADDR_W-1:0] y_w;
      logic [ADDR_W-1:0] x_w;
      y_w = ADDR_W'(y);
      x_w = ADDR_W'(x);
      if (screen_w == 160)
         return (y_w << 7) + (y_w << 5) + x_w;
      else
         return y_w * ADDR_W'(screen_w) + x_w;
   endfunction

endpackage

// File: rtl/pixel_write_sink_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
// Synchronous single-clock FIFO with a registered full flag.
//   clk, resetn      : clock, synchronous active-low reset
//   push, push_data  : write request/data (ignored while full)
//   pop, pop_data    : read request; pop_data shows the head entry
//   full             : registered, equals occupancy == DEPTH
//   empty            : occupancy == 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             do_push, do_pop;

   // NOTE: every signal written in always_comb gets a value on every path
   // (defaults first) so no latch can be inferred.
   always_comb begin
      // A push is refused on full_q even if a pop happens on the same edge.
      do_push  = push && !full_q;
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      full_d   = (count_d == CNT_W'(DEPTH));
   end

   // NOTE: sequential state is updated with non-blocking assignments only,
   // and the reset here is synchronous (sampled on the clock edge).
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and
   // count make stale entries unreachable, and an unreset array maps to RAM.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = (count_q == '0);

endmodule

// File: rtl/pixel_write_sink.sv
// ---------------------------------------------------------------------------
// pixel_write_sink
// Consumer end of the pixel-plot interface. Clips off-screen plots, buffers
// accepted pixels in a FIFO and drains them into the framebuffer RAM port
// with a held write request.
//   clk, resetn          : clock, synchronous active-low reset
//   plot, x, y, colour   : pixel write strobe and payload
//   busy                 : FIFO full; upstream must hold plot low
//   overflow             : sticky, a plot arrived while busy
//   fb_addr, fb_data     : framebuffer word address / colour
//   fb_we, fb_ready      : write request held until fb_we && fb_ready
//   drop_count           : saturating discarded-plot count (PIXEL_STATS_EN)
// Build option: define PIXEL_STATS_EN to add the drop_count output.
// ---------------------------------------------------------------------------
module pixel_write_sink #(
   parameter int FIFO_DEPTH = 4,
   parameter int SCREEN_W   = pixel_write_sink_pkg::SCREEN_W,
   parameter int SCREEN_H   = pixel_write_sink_pkg::SCREEN_H
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        plot,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [2:0]  colour,
   output logic        busy,
   output logic        overflow,
   output logic [14:0] fb_addr,
   output logic [2:0]  fb_data,
   output logic        fb_we,
   input  logic        fb_ready
`ifdef PIXEL_STATS_EN
   ,
   output logic [15:0] drop_count
`endif
);

   import pixel_write_sink_pkg::*;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
   logic [COLOUR_W-1:0] fb_data_q, fb_data_d;
   logic                overflow_q, overflow_d;

   pixel_t in_pix, head_pix;
   logic   on_screen, push, pop, fifo_full, fifo_empty;

   // ---------------- clip and push ----------------
   always_comb begin
      in_pix    = '{x: x, y: y, colour: colour};
      on_screen = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
      push      = plot && !fifo_full && on_screen;
   end

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIXEL_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (in_pix),
      .pop       (pop),
      .pop_data  (head_pix),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ---------------- write FSM ----------------
   always_ff @(posedge clk) begin
      if (!resetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty)             state_d = ST_WRITE;
         ST_WRITE: if (fb_ready && fifo_empty)  state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   // IDLE loads the head without waiting for fb_ready; WRITE reloads only on
   // an accepted write, which gives back-to-back writes at one per cycle.
   always_comb begin
      fb_we = (state_q == ST_WRITE);
      pop   = !fifo_empty && ((state_q == ST_IDLE) || fb_ready);
   end

   // ---------------- write datapath and status ----------------
   always_comb begin
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      if (pop) begin
         fb_addr_d = pixel_addr(head_pix.x, head_pix.y, SCREEN_W);
         fb_data_d = head_pix.colour;
      end
      overflow_d = overflow_q || (plot && fifo_full);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fb_addr_q  <= '0;
         fb_data_q  <= BLACK;
         overflow_q <= 1'b0;
      end else begin
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = fifo_full;
   assign overflow = overflow_q;
   assign fb_addr  = fb_addr_q;
   assign fb_data  = fb_data_q;

`ifdef PIXEL_STATS_EN
   logic [15:0] drop_count_q, drop_count_d;
   logic        discard;

   // A plot is dropped once, whether refused for being busy or clipped.
   always_comb begin
      discard      = plot && (fifo_full || !on_screen);
      drop_count_d = drop_count_q;
      if (discard && (drop_count_q != 16'hFFFF))
         drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         drop_count_q <= '0;
      else
         drop_count_q <= drop_count_d;
   end

   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_pixel_write_sink.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_sink
// Self-checking bench for pixel_write_sink. A queue-based reference model
// tracks buffered pixels, the pixel being written, overflow and drop count;
// every cycle the DUT outputs are compared against it. Inputs change just
// after the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pixel_write_sink;

   localparam int DEPTH = 4;
   localparam int W     = 160;
   localparam int H     = 120;
   localparam int NPIX  = W * H;

   logic        clk = 1'b0;
   logic        resetn;
   logic        plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        busy;
   logic        overflow;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_we;
   logic        fb_ready;
`ifdef PIXEL_STATS_EN
   logic [15:0] drop_count;
`endif

   always #5 clk = ~clk;

   pixel_write_sink #(
      .FIFO_DEPTH (DEPTH),
      .SCREEN_W   (W),
      .SCREEN_H   (H)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .plot       (plot),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .busy       (busy),
      .overflow   (overflow),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_we      (fb_we),
      .fb_ready   (fb_ready)
`ifdef PIXEL_STATS_EN
      ,
      .drop_count (drop_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   pix_t mq[$];        // pixels accepted but not yet presented
   pix_t cur;          // pixel presented on the RAM port (held when idle)
   bit   cur_v;        // a write request is outstanding
   bit   m_ovf;
   int   m_drops;
   int   writes;       // writes observed on the DUT port
   int   hits[NPIX];

   // One clock: count an accepted DUT write, advance the model on the rising
   // edge, then compare everything on the falling edge.
   task automatic cycle();
      bit full;
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
         writes++;
         if (int'(fb_addr) < NPIX) hits[fb_addr]++;
      end
      @(posedge clk);
      if (!resetn) begin
         mq.delete();
         cur_v   = 1'b0;
         cur     = '{0, 0, 0};
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         full = (mq.size() == DEPTH);
         if (mq.size() > 0 && (!cur_v || fb_ready)) begin
            cur   = mq.pop_front();
            cur_v = 1'b1;
         end else if (cur_v && fb_ready) begin
            cur_v = 1'b0;
         end
         if (plot) begin
            if (full) begin
               m_ovf = 1'b1;
               m_drops++;
            end else if (int'(x) >= W || int'(y) >= H) begin
               m_drops++;
            end else begin
               mq.push_back('{int'(x), int'(y), int'(colour)});
            end
         end
      end
      @(negedge clk);
      check("fb_we",    fb_we,    32'(cur_v));
      check("fb_addr",  fb_addr,  cur.y * W + cur.x);
      check("fb_data",  fb_data,  cur.c);
      check("busy",     busy,     32'(mq.size() == DEPTH));
      check("overflow", overflow, 32'(m_ovf));
`ifdef PIXEL_STATS_EN
      check("drop_count", drop_count, (m_drops > 65535) ? 65535 : m_drops);
`endif
   endtask

   task automatic drive(input bit p, input int xx, input int yy, input int cc, input bit rdy);
      plot     = p;
      x        = 8'(xx);
      y        = 7'(yy);
      colour   = 3'(cc);
      fb_ready = rdy;
      cycle();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drive(0, 0, 0, 0, 1);
      resetn = 1'b1;
   endtask

   initial begin
      int w0;
      int sent;
      int bad;

      resetn = 1'b0;
      plot = 1'b0; x = '0; y = '0; colour = '0; fb_ready = 1'b1;
      cur = '{0, 0, 0};
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      check("rst_fb_we",    fb_we,    0);
      check("rst_busy",     busy,     0);
      check("rst_overflow", overflow, 0);
      check("rst_fb_addr",  fb_addr,  0);
      check("rst_fb_data",  fb_data,  0);
      resetn = 1'b1;

      // Latency: plot sampled at edge N, request visible before edge N+2.
      drive(1, 5, 3, 5, 1);
      check("lat_n1_we", fb_we, 0);
      drive(0, 0, 0, 0, 1);
      check("lat_we",   fb_we,   1);
      check("lat_addr", fb_addr, 485);
      check("lat_data", fb_data, 5);
      drive(0, 0, 0, 0, 1);
      check("lat_idle", fb_we, 0);

      // Corner pixel and clipping.
      drive(1, 159, 119, 7, 1);
      drive(0, 0, 0, 0, 1);
      check("corner_addr", fb_addr, 19199);
      drive(0, 0, 0, 0, 1);
      drive(1, 160, 0, 3, 1);
      drive(1, 0, 120, 3, 1);
      drive(0, 0, 0, 0, 1);
      check("clip_no_we", fb_we, 0);
`ifdef PIXEL_STATS_EN
      check("clip_drops", drop_count, 2);
`endif

      // Stall the RAM: one pixel sits on the port, DEPTH fill the FIFO,
      // the sixth plot overflows.
      w0 = writes;
      for (int i = 0; i < 6; i++)
         drive(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 0);
      drive(0, 0, 0, 0, 0);
      check("stall_busy",     busy,     1);
      check("stall_overflow", overflow, 1);
      check("stall_no_write", writes - w0, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1);
      check("stall_drained", writes - w0, DEPTH + 1);

      // Stream 10 pixels while fb_ready toggles every cycle.
      w0   = writes;
      sent = 0;
      for (int i = 0; i < 200 && (sent < 10 || cur_v || mq.size() > 0); i++) begin
         if (sent < 10 && mq.size() < DEPTH) begin
            drive(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), i[0]);
            sent++;
         end else begin
            drive(0, 0, 0, 0, i[0]);
         end
      end
      check("toggle_writes", writes - w0, 10);

      // Reset while writing with entries queued.
      for (int i = 0; i < 4; i++)
         drive(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 0);
      drive(0, 0, 0, 0, 0);
      check("pre_rst_we", fb_we, 1);
      resetn = 1'b0;
      drive(0, 0, 0, 0, 0);
      check("mid_rst_we",       fb_we,    0);
      check("mid_rst_busy",     busy,     0);
      check("mid_rst_overflow", overflow, 0);
      resetn = 1'b1;
      w0 = writes;
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1);
      check("post_rst_no_write", writes - w0, 0);

      // Random traffic including off-screen and overflowing plots.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 1), $urandom_range(0, 175), $urandom_range(0, 127),
               $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1);

      // Full-screen blanking sweep.
      do_reset();
      for (int i = 0; i < NPIX; i++) hits[i] = 0;
      w0 = writes;
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            drive(1, xx, yy, 0, 1);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1);
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (hits[i] != 1) bad++;
      check("sweep_writes",   writes - w0, NPIX);
      check("sweep_hits_bad", bad,         0);
      check("sweep_overflow", overflow,    0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
